// File: rtl/pc_sequencer.sv
// Program-counter sequencer: one-cycle BOOT, then sequential or taken-flow PC
// updates, held while memory asserts BUSYWAIT. Counts retired instructions.
module pc_sequencer (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        BUSYWAIT,
    input  logic        FLOW_SELECT,
    input  logic [7:0]  OFFSET,
    output logic [31:0] PC,
    output logic [31:0] PC_PLUS4,
    output logic [31:0] TARGET,
    output logic        FETCH_VALID,
    output logic        STALLED,
    output logic        REDIRECT,
    output logic [15:0] INSTR_COUNT,
    output logic [1:0]  DBG_STATE
);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [15:0] cnt_q, cnt_d;
    logic        redirect_q, redirect_d;
    logic [31:0] offset_bytes;

    // Handshake: FETCH_VALID is the fetch-side valid and ~BUSYWAIT is memory
    // ready; an instruction retires on a rising edge where both are high.
    assign offset_bytes = {{22{OFFSET[7]}}, OFFSET, 2'b00};
    assign PC_PLUS4     = pc_q + 32'd4;
    assign TARGET       = PC_PLUS4 + offset_bytes;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        redirect_d = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN, ST_STALL: begin
                if (BUSYWAIT) begin
                    state_d = ST_STALL;
                end else begin
                    state_d    = ST_RUN;
                    pc_d       = FLOW_SELECT ? TARGET : PC_PLUS4;
                    redirect_d = FLOW_SELECT;
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_BOOT;
            pc_q       <= 32'd0;
            cnt_q      <= 16'd0;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            redirect_q <= redirect_d;
        end
    end

    assign PC          = {pc_q[31:2], 2'b00};
    assign FETCH_VALID = (state_q == ST_RUN) || (state_q == ST_STALL);
    assign STALLED     = (state_q == ST_STALL);
    assign REDIRECT    = redirect_q;
    assign INSTR_COUNT = cnt_q;
    assign DBG_STATE   = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, sequential fetch, branches, stalls,
// wrap-around, offset sign extension, counter saturation and mid-stall reset.
module tb_pc_sequencer;

    logic        CLK;
    logic        RESET;
    logic        BUSYWAIT;
    logic        FLOW_SELECT;
    logic [7:0]  OFFSET;
    logic [31:0] PC;
    logic [31:0] PC_PLUS4;
    logic [31:0] TARGET;
    logic        FETCH_VALID;
    logic        STALLED;
    logic        REDIRECT;
    logic [15:0] INSTR_COUNT;
    logic [1:0]  DBG_STATE;

    int n_checks;
    int n_fails;
    logic [15:0] exp_cnt;

    pc_sequencer dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .BUSYWAIT    (BUSYWAIT),
        .FLOW_SELECT (FLOW_SELECT),
        .OFFSET      (OFFSET),
        .PC          (PC),
        .PC_PLUS4    (PC_PLUS4),
        .TARGET      (TARGET),
        .FETCH_VALID (FETCH_VALID),
        .STALLED     (STALLED),
        .REDIRECT    (REDIRECT),
        .INSTR_COUNT (INSTR_COUNT),
        .DBG_STATE   (DBG_STATE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] pc, input logic fv,
                             input logic st, input logic rd, input logic [15:0] cnt);
        chk({tag, " pc"}, PC, pc);
        chk({tag, " fetch_valid"}, {31'd0, FETCH_VALID}, {31'd0, fv});
        chk({tag, " stalled"}, {31'd0, STALLED}, {31'd0, st});
        chk({tag, " redirect"}, {31'd0, REDIRECT}, {31'd0, rd});
        chk({tag, " count"}, {16'd0, INSTR_COUNT}, {16'd0, cnt});
    endtask

    initial begin
        n_checks    = 0;
        n_fails     = 0;
        RESET       = 1'b0;
        BUSYWAIT    = 1'b0;
        FLOW_SELECT = 1'b0;
        OFFSET      = 8'h00;

        // Reset state, held across edges with a taken branch pending
        #3;
        chk_state("reset", 32'h0, 1'b0, 1'b0, 1'b0, 16'd0);
        FLOW_SELECT = 1'b1;
        OFFSET      = 8'h10;
        tick();
        tick();
        chk_state("reset_hold", 32'h0, 1'b0, 1'b0, 1'b0, 16'd0);
        FLOW_SELECT = 1'b0;
        OFFSET      = 8'h00;
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        chk_state("boot_pre", 32'h0, 1'b0, 1'b0, 1'b0, 16'd0);

        // Sequential fetch: 0,0,4,8,12
        tick();
        chk_state("boot_edge", 32'h0, 1'b1, 1'b0, 1'b0, 16'd0);
        tick();
        chk_state("seq1", 32'h4, 1'b1, 1'b0, 1'b0, 16'd1);
        tick();
        chk_state("seq2", 32'h8, 1'b1, 1'b0, 1'b0, 16'd2);
        tick();
        chk_state("seq3", 32'hC, 1'b1, 1'b0, 1'b0, 16'd3);
        chk("seq3 pc_plus4", PC_PLUS4, 32'h10);
        tick();
        chk("seq4 pc", PC, 32'h10);

        // Backward branch with OFFSET=0xFE from 0x10
        FLOW_SELECT = 1'b1;
        OFFSET      = 8'hFE;
        #1;
        chk("br_back target", TARGET, 32'hC);
        tick();
        chk_state("br_back", 32'hC, 1'b1, 1'b0, 1'b1, 16'd5);
        FLOW_SELECT = 1'b0;
        tick();
        chk_state("br_back_after", 32'h10, 1'b1, 1'b0, 1'b0, 16'd6);
        tick();
        tick();
        tick();
        tick();
        chk("to_0x20 pc", PC, 32'h20);

        // Stall for 3 edges while FLOW_SELECT toggles
        BUSYWAIT = 1'b1;
        for (int i = 0; i < 3; i++) begin
            FLOW_SELECT = i[0] ? 1'b0 : 1'b1;
            OFFSET      = 8'($urandom_range(0, 255));
            tick();
            chk_state($sformatf("stall%0d", i), 32'h20, 1'b1, 1'b1, 1'b0, 16'd10);
        end
        BUSYWAIT    = 1'b0;
        FLOW_SELECT = 1'b1;
        OFFSET      = 8'h02;
        tick();
        chk_state("stall_release", 32'h2C, 1'b1, 1'b0, 1'b1, 16'd11);

        // Reset pulsed between edges during STALL
        BUSYWAIT = 1'b1;
        tick();
        chk("pre_rst stalled", {31'd0, STALLED}, 32'd1);
        #2;
        RESET = 1'b0;
        #1;
        chk_state("mid_rst", 32'h0, 1'b0, 1'b0, 1'b0, 16'd0);
        chk("mid_rst state", {30'd0, DBG_STATE}, 32'd0);
        @(negedge CLK);
        RESET = 1'b1;
        tick();
        chk_state("boot_ignores", 32'h0, 1'b1, 1'b0, 1'b0, 16'd0);
        BUSYWAIT    = 1'b0;
        FLOW_SELECT = 1'b0;
        tick();
        chk_state("first_update", 32'h4, 1'b1, 1'b0, 1'b0, 16'd1);

        // Wrap: jump to 0xFFFFFFFC, then +4 wraps to 0
        FLOW_SELECT = 1'b1;
        OFFSET      = 8'hFD;
        tick();
        chk("to_top pc", PC, 32'hFFFF_FFFC);
        FLOW_SELECT = 1'b0;
        #1;
        chk("top pc_plus4", PC_PLUS4, 32'h0);
        tick();
        chk("wrap pc", PC, 32'h0);

        // Sign extension: +0x3F to 0x100, 0x80 wraps below 0, 0x7F, 0xFF
        FLOW_SELECT = 1'b1;
        OFFSET      = 8'h3F;
        tick();
        chk("to_0x100 pc", PC, 32'h100);
        OFFSET = 8'h80;
        tick();
        chk("neg_max pc", PC, 32'hFFFF_FF04);
        OFFSET = 8'h7F;
        tick();
        chk("pos_max pc", PC, 32'h104);
        OFFSET = 8'hFF;
        #1;
        chk("self target", TARGET, 32'h104);
        tick();
        chk_state("self_jump", 32'h104, 1'b1, 1'b0, 1'b1, 16'd7);

        // Saturation: run up to 0xFFFE, then 3 more updates
        FLOW_SELECT = 1'b0;
        exp_cnt = 16'd7;
        while (exp_cnt != 16'hFFFE) begin
            tick();
            exp_cnt++;
        end
        chk("sat_pre count", {16'd0, INSTR_COUNT}, 32'h0000_FFFE);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("sat%0d count", i), {16'd0, INSTR_COUNT}, 32'h0000_FFFF);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have port CLK, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 The block SHALL have port RESET, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The block SHALL have port BUSYWAIT, input, 1 bit: memory stall request; high holds the PC.
REQ-004 The block SHALL have port FLOW_SELECT, input, 1 bit: take branch/jump for the current instruction; driven as JUMP | (BRANCH & ZERO).
REQ-005 The block SHALL have port OFFSET, input, 8 bits: signed word offset of the current branch/jump instruction.
REQ-006 The block SHALL have port PC, output, 32 bits: registered program counter, the current fetch address.
REQ-007 The block SHALL have port PC_PLUS4, output, 32 bits: combinational PC + 4.
REQ-008 The block SHALL have port TARGET, output, 32 bits: combinational PC + 4 + (sign-extended OFFSET << 2).
REQ-009 The block SHALL have port FETCH_VALID, output, 1 bit: high when PC is a valid fetch address.
REQ-010 The block SHALL have port STALLED, output, 1 bit: high while in STALL state.
REQ-011 The block SHALL have port REDIRECT, output, 1 bit: registered one-cycle pulse, high after a taken-flow PC update.
REQ-012 The block SHALL have port INSTR_COUNT, output, 16 bits: count of retired instructions, saturating.

Function
REQ-013 The FSM SHALL have states BOOT, RUN and STALL.
REQ-014 BOOT SHALL last exactly one cycle with FETCH_VALID=0 and PC held at 0, then go to RUN unconditionally, ignoring BUSYWAIT and FLOW_SELECT.
REQ-015 RUN/STALL, rising edge with BUSYWAIT=0: PC <= TARGET if FLOW_SELECT=1, else PC_PLUS4; INSTR_COUNT increments; REDIRECT <= FLOW_SELECT; next state RUN.
REQ-016 RUN/STALL, rising edge with BUSYWAIT=1: PC, INSTR_COUNT held; REDIRECT <= 0; next state STALL.
REQ-017 FLOW_SELECT and OFFSET SHALL be sampled only at the updating edge; their values during stalled cycles SHALL have no effect.
REQ-018 FETCH_VALID SHALL be 1 in RUN and STALL; STALLED SHALL be 1 only in STALL.
REQ-019 All PC arithmetic SHALL be 32-bit modulo 2^32: 0xFFFFFFFC + 4 = 0x00000000, and negative offsets wrap below 0.
REQ-020 OFFSET SHALL be sign-extended from bit 7: 0x7F gives +508 bytes, 0x80 gives -512 bytes, and 0xFF gives TARGET = PC.
REQ-021 PC[1:0] SHALL always be 2'b00.
REQ-022 INSTR_COUNT SHALL saturate at 0xFFFF, with no wrap.
REQ-023 The update latency from the sampling edge to the new PC SHALL be one edge; PC_PLUS4 and TARGET SHALL follow PC combinationally in the same cycle.

Reset
REQ-024 RESET=0 SHALL immediately and asynchronously force PC=0, INSTR_COUNT=0, REDIRECT=0, state=BOOT, FETCH_VALID=0 and STALLED=0, independent of CLK.
REQ-025 Reset asserted mid-STALL or in the same cycle as a taken branch SHALL discard the pending update; reset SHALL win over all other inputs.
REQ-026 After RESET returns to 1, the first rising edge SHALL perform only BOOT->RUN, and the second edge SHALL be the first PC update.

Verification
REQ-027 Reset release, BUSYWAIT=0, FLOW_SELECT=0 for 4 edges: PC SHALL read 0,0,4,8,12; FETCH_VALID=0 then 1; INSTR_COUNT=3.
REQ-028 PC=0x10, FLOW_SELECT=1, OFFSET=0xFE: next PC SHALL be 0x0C, with REDIRECT=1 for one cycle, then 0.
REQ-029 PC=0x20, BUSYWAIT=1 for 3 edges while FLOW_SELECT toggles, then BUSYWAIT=0 with FLOW_SELECT=1, OFFSET=0x02: PC SHALL hold 0x20 with STALLED=1 for 3 cycles, then become 0x2C.
REQ-030 PC=0xFFFFFFFC, FLOW_SELECT=0: next PC SHALL be 0x00000000; with OFFSET=0x80 at PC=0x100, next PC SHALL be 0xFFFFFF04.
REQ-031 INSTR_COUNT forced to 0xFFFE, then 3 updates: INSTR_COUNT SHALL be 0xFFFF and stay there.
REQ-032 RESET pulsed low between clock edges during STALL: PC and INSTR_COUNT SHALL clear within the same cycle, and the BOOT cycle SHALL follow.
